// File: rtl/rom_pkg.sv
// Shared types and defaults for the ROM stream sequencer.
// The FSM state enum is exported here so checkers can decode the debug port.
package rom_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_MEM_DEPTH  = 16;
  localparam logic [DEF_DATA_WIDTH-1:0] DEF_TERM = 8'h00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EMIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/rom_stream_ctrl_if.sv
// Byte stream carrying fetched ROM words to a consumer.
// Handshake: a beat transfers on a rising clk edge where out_valid and out_ready are both 1;
// while out_valid is high and out_ready is low, out_data and out_last hold steady.
interface rom_stream_ctrl_if #(
  parameter int DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;

  modport master (
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/rom_stream_ctrl.sv
// Walks an external combinational ROM from a base address and streams each byte,
// ending on a byte count or, optionally, on a terminator value.
module rom_stream_ctrl
  import rom_pkg::*;
#(
  parameter int                    DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int                    MEM_DEPTH    = DEF_MEM_DEPTH,
  parameter int                    ADDR_WIDTH   = $clog2(MEM_DEPTH),
  parameter logic [DATA_WIDTH-1:0] TERM         = DEF_TERM,
  parameter bit                    STOP_ON_TERM = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   max_len,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  rom_re,
  output logic                  rom_ce,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output state_t                state_dbg,
  rom_stream_ctrl_if.master     out_if
);

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH:0]   remaining;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  out_valid_q;
  logic                  out_last_q;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   ONE       = (ADDR_WIDTH + 1)'(1);

  assign rom_addr         = addr;
  assign state_dbg        = state;
  assign out_if.out_data  = out_data_q;
  assign out_if.out_valid = out_valid_q;
  assign out_if.out_last  = out_last_q;

  // All outputs are registered; rom_ce/rom_re are set on entry to FETCH and cleared on exit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      addr        <= '0;
      remaining   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      rom_re      <= 1'b0;
      rom_ce      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (max_len != '0) begin
              addr      <= base_addr;
              remaining <= max_len;
              busy      <= 1'b1;
              rom_ce    <= 1'b1;
              rom_re    <= 1'b1;
              state     <= FETCH;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end

        FETCH: begin
          out_data_q <= rom_data;
          rom_ce     <= 1'b0;
          rom_re     <= 1'b0;
          if (STOP_ON_TERM && (rom_data == TERM)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            out_valid_q <= 1'b1;
            out_last_q  <= (remaining == ONE);
            state       <= EMIT;
          end
        end

        EMIT: begin
          if (out_if.out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            remaining   <= remaining - ONE;
            if (remaining == ONE) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              // Explicit compare keeps the wrap correct for non-power-of-2 depths.
              addr   <= (addr == LAST_ADDR) ? '0 : addr + 1'b1;
              rom_ce <= 1'b1;
              rom_re <= 1'b1;
              state  <= FETCH;
            end
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_stream_ctrl.sv
// Directed bench: one terminator-enabled and one length-only instance share stimulus
// buses; each has its own start line and ROM model, and sel picks which one is observed.
module tb_rom_stream_ctrl;
  import rom_pkg::*;

  logic       clk;
  logic       rst;
  logic       start_a, start_b;
  logic [3:0] base_addr;
  logic [4:0] max_len;
  logic       out_ready;
  logic       sel;

  logic       busy_a, done_a, re_a, ce_a;
  logic       busy_b, done_b, re_b, ce_b;
  logic [3:0] addr_a, addr_b;
  logic [7:0] data_a, data_b;
  state_t     st_a, st_b;

  rom_stream_ctrl_if #(.DATA_WIDTH(8)) if_a ();
  rom_stream_ctrl_if #(.DATA_WIDTH(8)) if_b ();

  assign if_a.out_ready = out_ready;
  assign if_b.out_ready = out_ready;

  rom_stream_ctrl #(.STOP_ON_TERM(1'b1)) u_dut_term (
    .clk(clk), .rst(rst), .start(start_a), .base_addr(base_addr), .max_len(max_len),
    .busy(busy_a), .done(done_a), .rom_addr(addr_a), .rom_re(re_a), .rom_ce(ce_a),
    .rom_data(data_a), .state_dbg(st_a), .out_if(if_a)
  );

  rom_stream_ctrl #(.STOP_ON_TERM(1'b0)) u_dut_len (
    .clk(clk), .rst(rst), .start(start_b), .base_addr(base_addr), .max_len(max_len),
    .busy(busy_b), .done(done_b), .rom_addr(addr_b), .rom_re(re_b), .rom_ce(ce_b),
    .rom_data(data_b), .state_dbg(st_b), .out_if(if_b)
  );

  // Character ROM: 0..3 = "JARI", everything else 00.
  function automatic logic [7:0] rom_word(input logic [3:0] a);
    case (a)
      4'd0:    rom_word = 8'h4A;
      4'd1:    rom_word = 8'h41;
      4'd2:    rom_word = 8'h52;
      4'd3:    rom_word = 8'h49;
      default: rom_word = 8'h00;
    endcase
  endfunction

  assign data_a = (ce_a && re_a) ? rom_word(addr_a) : 8'h00;
  assign data_b = (ce_b && re_b) ? rom_word(addr_b) : 8'h00;

  logic [7:0] o_data;
  logic [3:0] o_addr;
  logic       o_valid, o_last, o_done, o_busy, o_ce, o_re;

  always_comb begin
    if (sel) begin
      o_data = if_b.out_data; o_valid = if_b.out_valid; o_last = if_b.out_last;
      o_done = done_b; o_busy = busy_b; o_ce = ce_b; o_re = re_b; o_addr = addr_b;
    end else begin
      o_data = if_a.out_data; o_valid = if_a.out_valid; o_last = if_a.out_last;
      o_done = done_a; o_busy = busy_a; o_ce = ce_a; o_re = re_a; o_addr = addr_a;
    end
  end

  // Clock / reset / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int tests_run;
  int tests_failed;

  // Scoreboard state filled by collect()
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic       last_q[$];
  logic [3:0] addr_q[$];
  int ce_cnt, re_cnt, ce_while_valid, done_cnt, done_cyc, hs_cyc, fetch_cyc, beat_vis;
  bit timed_out;

  task automatic pulse_start(input bit s, input logic [3:0] b, input logic [4:0] l);
    sel       = s;
    base_addr = b;
    max_len   = l;
    if (s) start_b = 1'b1;
    else   start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // Called at the negedge after the start edge; runs until done or budget expires.
  task automatic collect(input int budget, input int stall_beat, input int stall_n);
    int cyc;
    int left;
    bit fin;
    got_q.delete(); last_q.delete(); addr_q.delete();
    ce_cnt = 0; re_cnt = 0; ce_while_valid = 0; done_cnt = 0;
    done_cyc = -1; hs_cyc = -1; fetch_cyc = -1; beat_vis = 0;
    left = stall_n; fin = 1'b0; cyc = 0;
    while (!fin && cyc < budget) begin
      if (o_ce) begin
        ce_cnt++; addr_q.push_back(o_addr); fetch_cyc = cyc;
        if (o_valid) ce_while_valid++;
      end
      if (o_re) re_cnt++;
      if (o_done) begin done_cnt++; done_cyc = cyc; fin = 1'b1; end
      if (o_valid) begin
        if (got_q.size() == stall_beat) beat_vis++;
        if (got_q.size() == stall_beat && left > 0) begin
          out_ready = 1'b0; left--;
        end else begin
          out_ready = 1'b1;
          got_q.push_back(o_data); last_q.push_back(o_last); hs_cyc = cyc;
        end
      end else begin
        out_ready = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    timed_out = !fin;
    out_ready = 1'b1;
  endtask

  task automatic check_beats(input string name, input int last_idx);
    if (got_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL %s beat count: got %0d expected %0d", name, got_q.size(), exp_q.size());
    end
    tests_run++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      tests_run++;
      if (got_q[i] !== exp_q[i] || last_q[i] !== (i == last_idx)) begin
        tests_failed++;
        $display("FAIL %s beat %0d: got data %h last %b expected data %h last %b",
                 name, i, got_q[i], last_q[i], exp_q[i], (i == last_idx));
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests_run++;
    if (if_a.out_valid !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0 || ce_a !== 1'b0 ||
        re_a !== 1'b0 || addr_a !== 4'd0 || if_a.out_data !== 8'h00 || if_a.out_last !== 1'b0 ||
        st_a !== IDLE) begin
      tests_failed++;
      $display("FAIL reset_a: valid %b busy %b done %b ce %b re %b addr %0d data %h last %b, expected all 0",
               if_a.out_valid, busy_a, done_a, ce_a, re_a, addr_a, if_a.out_data, if_a.out_last);
    end
    tests_run++;
    if (if_b.out_valid !== 1'b0 || busy_b !== 1'b0 || done_b !== 1'b0 || ce_b !== 1'b0 ||
        addr_b !== 4'd0 || if_b.out_data !== 8'h00 || st_b !== IDLE) begin
      tests_failed++;
      $display("FAIL reset_b: valid %b busy %b done %b ce %b addr %0d data %h, expected all 0",
               if_b.out_valid, busy_b, done_b, ce_b, addr_b, if_b.out_data);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    pulse_start(1'b0, 4'd0, 5'd4);
    tests_run++;
    if (o_busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic busy in FETCH: got %b expected 1", o_busy);
    end
    collect(40, -1, 0);
    exp_q = '{8'h4A, 8'h41, 8'h52, 8'h49};
    check_beats("basic", 3);
    tests_run++;
    if (timed_out || done_cnt != 1 || done_cyc != hs_cyc + 1) begin
      tests_failed++;
      $display("FAIL basic done: timeout %b count %0d at cycle %0d, expected 1 at cycle %0d",
               timed_out, done_cnt, done_cyc, hs_cyc + 1);
    end
    tests_run++;
    if (ce_cnt != 4 || re_cnt != 4) begin
      tests_failed++;
      $display("FAIL basic rom access: ce %0d re %0d cycles, expected 4", ce_cnt, re_cnt);
    end
    tests_run++;
    if (addr_q.size() != 4 || addr_q[0] !== 4'd0 || addr_q[3] !== 4'd3) begin
      tests_failed++;
      $display("FAIL basic addresses: got %0d fetches, expected 0..3", addr_q.size());
    end
  endtask

  task automatic test_terminator();
    pulse_start(1'b0, 4'd2, 5'd6);
    collect(40, -1, 0);
    exp_q = '{8'h52, 8'h49};
    check_beats("term", -1);
    tests_run++;
    if (addr_q.size() != 3 || addr_q[2] !== 4'd4) begin
      tests_failed++;
      $display("FAIL term fetches: got %0d fetches, expected 3 ending at address 4", addr_q.size());
    end
    tests_run++;
    if (timed_out || done_cnt != 1 || done_cyc != fetch_cyc + 1) begin
      tests_failed++;
      $display("FAIL term done: timeout %b count %0d at cycle %0d, expected 1 at cycle %0d",
               timed_out, done_cnt, done_cyc, fetch_cyc + 1);
    end
  endtask

  task automatic test_backpressure();
    pulse_start(1'b0, 4'd0, 5'd4);
    collect(60, 1, 3);
    exp_q = '{8'h4A, 8'h41, 8'h52, 8'h49};
    check_beats("stall", 3);
    tests_run++;
    if (beat_vis != 4) begin
      tests_failed++;
      $display("FAIL stall hold: 41 visible %0d cycles, expected 4", beat_vis);
    end
    tests_run++;
    if (ce_while_valid != 0 || ce_cnt != 4) begin
      tests_failed++;
      $display("FAIL stall rom access: ce during valid %0d total %0d, expected 0 and 4",
               ce_while_valid, ce_cnt);
    end
    tests_run++;
    if (timed_out || done_cnt != 1) begin
      tests_failed++;
      $display("FAIL stall done: timeout %b count %0d, expected 1", timed_out, done_cnt);
    end
  endtask

  task automatic test_wrap();
    pulse_start(1'b1, 4'd14, 5'd4);
    collect(40, -1, 0);
    exp_q = '{8'h00, 8'h00, 8'h4A, 8'h41};
    check_beats("wrap", 3);
    tests_run++;
    if (addr_q.size() != 4 || addr_q[0] !== 4'd14 || addr_q[1] !== 4'd15 ||
        addr_q[2] !== 4'd0 || addr_q[3] !== 4'd1) begin
      tests_failed++;
      $display("FAIL wrap addresses: got %0d fetches, expected 14 15 0 1", addr_q.size());
    end
    tests_run++;
    if (timed_out || done_cnt != 1) begin
      tests_failed++;
      $display("FAIL wrap done: timeout %b count %0d, expected 1", timed_out, done_cnt);
    end
  endtask

  task automatic test_zero_len();
    int dn, vl, ce;
    pulse_start(1'b0, 4'd0, 5'd0);
    tests_run++;
    if (o_done !== 1'b1 || o_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_len done: got done %b busy %b expected 1 0", o_done, o_busy);
    end
    dn = 1; vl = 0; ce = 0;
    // A second start lands while the first one is in DONE and must be dropped.
    max_len = 5'd3;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (o_done) dn++;
      if (o_valid) vl++;
      if (o_ce) ce++;
      @(negedge clk);
    end
    tests_run++;
    if (dn != 1 || vl != 0 || ce != 0) begin
      tests_failed++;
      $display("FAIL zero_len ignore: done %0d valid %0d ce %0d cycles, expected 1 0 0", dn, vl, ce);
    end
  endtask

  task automatic test_reset_abort();
    int waited;
    int dn;
    pulse_start(1'b0, 4'd0, 5'd4);
    out_ready = 1'b0;
    waited = 0;
    while (!o_valid && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    tests_run++;
    if (!o_valid) begin
      tests_failed++;
      $display("FAIL abort setup: out_valid never rose within 10 cycles");
    end
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_ce !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort immediate: valid %b busy %b ce %b, expected 0 0 0", o_valid, o_busy, o_ce);
    end
    dn = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (o_done) dn++;
    end
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (o_done) dn++;
    end
    tests_run++;
    if (dn != 0) begin
      tests_failed++;
      $display("FAIL abort done: saw %0d done cycles, expected 0", dn);
    end
    pulse_start(1'b0, 4'd1, 5'd2);
    collect(40, -1, 0);
    exp_q = '{8'h41, 8'h52};
    check_beats("after_reset", 1);
    tests_run++;
    if (timed_out || done_cnt != 1) begin
      tests_failed++;
      $display("FAIL after_reset done: timeout %b count %0d, expected 1", timed_out, done_cnt);
    end
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; sel = 1'b0;
    base_addr = '0; max_len = '0; out_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_terminator();
    test_backpressure();
    test_wrap();
    test_zero_len();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/rom_stream_ctrl.md
Name: rom_stream_ctrl

Overview:
- Sequencer in front of the team's combinational character ROM (address / read_enable / chip_enable in, data_out back).
- On a start command it walks the ROM from a base address for up to a programmed length, or until a terminator byte if enabled.
- Each fetched byte is presented on a valid/ready output stream, and a done pulse marks the end.
- Sits between the ROM and any byte consumer, such as a UART transmitter or display driver.

Parameters:
- DATA_WIDTH, 8: ROM word width and stream data width.
- MEM_DEPTH, 16: number of ROM words.
- ADDR_WIDTH, $clog2(MEM_DEPTH): ROM address width.
- TERM, 8'h00: terminator value.
- STOP_ON_TERM, 1: 1 = a fetched byte equal to TERM ends the transfer; 0 = length only.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin transfer; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  first ROM address; latched on start.
- max_len  in  ADDR_WIDTH+1  byte count, 0..2*MEM_DEPTH-1; latched on start.
- busy  out  1  high in FETCH and EMIT.
- done  out  1  one-cycle pulse at the end of every accepted start.
- rom_addr  out  ADDR_WIDTH  ROM address.
- rom_re  out  1  ROM read_enable.
- rom_ce  out  1  ROM chip_enable.
- rom_data  in  DATA_WIDTH  ROM data_out, combinational from rom_addr.
- out_data  out  DATA_WIDTH  stream byte.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready.
- out_last  out  1  high with the final byte of a length-terminated transfer.

Behaviour:
- Interface: one clock domain, clk; rst is asynchronous and active-high.
- Reset: state IDLE; addr register, remaining count and out_data all 0; busy, done, rom_re, rom_ce, out_valid, out_last all 0.
  - Reset mid-transfer aborts immediately. No done pulse is produced.
- Registers:
  - addr[ADDR_WIDTH-1:0] drives rom_addr at all times.
  - remaining[ADDR_WIDTH:0] holds the bytes still to be emitted.
- IDLE:
  - start=1 with max_len!=0: addr<=base_addr, remaining<=max_len, go to FETCH.
  - start=1 with max_len==0: go to DONE; no ROM access.
  - start=0: stay in IDLE.
- FETCH (exactly one cycle):
  - rom_ce=1 and rom_re=1; these are asserted only in this state.
  - At the clock edge out_data<=rom_data.
  - If STOP_ON_TERM=1 and rom_data==TERM: go to DONE; the terminator is not emitted.
  - Otherwise go to EMIT with out_valid<=1 and out_last<=(remaining==1).
- EMIT:
  - out_valid, out_data and out_last stay stable until out_ready=1 is sampled (handshake).
  - On handshake: out_valid<=0 and remaining<=remaining-1.
  - If remaining==1, go to DONE.
  - Otherwise addr<=addr+1, wrapping from MEM_DEPTH-1 to 0 with an explicit compare (valid for non-power-of-2 depths), and go to FETCH.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE.
  - start is ignored here and in FETCH/EMIT; no queuing.
- Latency: the first out_valid rises 2 cycles after start is sampled. Throughput is at most 1 byte per 2 cycles.
- max_len greater than MEM_DEPTH re-reads the ROM after the wrap; this is legal.
- A transfer ended by the terminator carries no out_last; done is the only end marker.
- base_addr and max_len changes while busy have no effect.

Decomposition:
- Shared package rom_pkg:
  - state enum {IDLE, FETCH, EMIT, DONE}
  - DATA_WIDTH and MEM_DEPTH defaults
  - TERM constant
- No sub-module: a single FSM plus counters.
- The ROM stays external. The testbench instantiates the existing ROM and ties its ports to rom_*.

Test Plan (ROM contents: addresses 0..3 = 4A 41 52 49, all others 00):
1. base=0, len=4, out_ready=1 -> beats 4A, 41, 52, 49; out_last only on 49; done one cycle after the 49 handshake; rom_ce high in exactly 4 cycles.
2. STOP_ON_TERM=1, base=2, len=6 -> beats 52, 49; 00 fetched at address 4; done next cycle; 2 beats, no out_last.
3. Backpressure: base=0, len=4, out_ready low for 3 cycles while 41 is valid -> out_data stays 41 and out_valid stays high throughout; no ROM access during the stall; sequence completes intact.
4. Wrap: STOP_ON_TERM=0, base=14, len=4 -> rom_addr 14, 15, 0, 1; beats 00, 00, 4A, 41; out_last on 41.
5. len=0 start -> done high in the following cycle; no out_valid, no rom_ce. A second start pulsed during DONE is ignored, so only one done is seen.
6. rst asserted mid-EMIT (between clock edges) -> out_valid, busy and rom_ce drop immediately with no done. After release, base=1, len=2 -> beats 41, 52.
